// File: rtl/sa_pkg.sv
// Shared sizes and FSM state type for the 4x4 systolic array controller.
package sa_pkg;

   localparam int N           = 4;
   localparam int DATA_W      = 8;
   localparam int ACC_W       = 32;
   localparam int FEED_CYCLES = 7;
   localparam int K_W         = 3;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      DONE
   } sa_state_t;

endpackage

// File: rtl/sa_skew_feeder.sv
// Combinational skew selection: maps latched A/B and feed step k onto the
// eight diagonal-wavefront operands at the array edges.
module sa_skew_feeder
   import sa_pkg::*;
(
   input  logic [N*N*DATA_W-1:0] a_lat,
   input  logic [N*N*DATA_W-1:0] b_lat,
   input  logic [K_W-1:0]        k,
   input  logic                  feed_en,
   output logic [N*DATA_W-1:0]   a_op,
   output logic [N*DATA_W-1:0]   b_op
);

   // Row i (and column i) lags row 0 by i cycles so products meet in each PE.
   always_comb begin
      a_op = '0;
      b_op = '0;
      for (int i = 0; i < N; i++) begin
         if (feed_en && (int'(k) >= i) && (int'(k) - i < N)) begin
            a_op[i*DATA_W +: DATA_W] = a_lat[(i*N + int'(k) - i)*DATA_W +: DATA_W];
            b_op[i*DATA_W +: DATA_W] = b_lat[((int'(k) - i)*N + i)*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/systolic_array_4x4.sv
// Output-stationary 4x4 signed MAC array: A flows right, B flows down,
// each PE accumulates its own C[i][j].
module systolic_array_4x4
   import sa_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic [N*DATA_W-1:0]    a_in,
   input  logic [N*DATA_W-1:0]    b_in,
   output logic [N*N*ACC_W-1:0]   c_out
);

   logic signed [DATA_W-1:0]   a_reg [N][N];
   logic signed [DATA_W-1:0]   b_reg [N][N];
   logic signed [DATA_W-1:0]   a_w   [N][N];
   logic signed [DATA_W-1:0]   b_w   [N][N];
   logic signed [2*DATA_W-1:0] prod  [N][N];
   logic signed [ACC_W-1:0]    acc   [N][N];

   // Each PE sees its left/upper neighbour's registered operand, or the edge input.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            a_w[i][j] = (j == 0) ? a_in[i*DATA_W +: DATA_W] : a_reg[i][(j == 0) ? 0 : j-1];
            b_w[i][j] = (i == 0) ? b_in[j*DATA_W +: DATA_W] : b_reg[(i == 0) ? 0 : i-1][j];
            prod[i][j] = a_w[i][j] * b_w[i][j];
            c_out[(i*N + j)*ACC_W +: ACC_W] = acc[i][j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_reg[i][j] <= '0;
               b_reg[i][j] <= '0;
               acc[i][j]   <= '0;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               if (clear) begin
                  a_reg[i][j] <= '0;
                  b_reg[i][j] <= '0;
                  acc[i][j]   <= '0;
               end else begin
                  a_reg[i][j] <= a_w[i][j];
                  b_reg[i][j] <= b_w[i][j];
                  acc[i][j]   <= acc[i][j] +
                                 {{(ACC_W-2*DATA_W){prod[i][j][2*DATA_W-1]}}, prod[i][j]};
               end
            end
         end
      end
   end

endmodule

// File: rtl/systolic_ctrl_4x4.sv
// Job controller for a 4x4 systolic array: clear, skewed feed, drain, capture.
// Optional completed-job counter enabled by defining SA_CTRL_PERF_EN.
module systolic_ctrl_4x4
   import sa_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_valid,
   output logic                  start_ready,
   input  logic [N*N*DATA_W-1:0] a_mat,
   input  logic [N*N*DATA_W-1:0] b_mat,
   input  logic                  abort,
   output logic [DATA_W-1:0]     arr_a1,
   output logic [DATA_W-1:0]     arr_a2,
   output logic [DATA_W-1:0]     arr_a3,
   output logic [DATA_W-1:0]     arr_a4,
   output logic [DATA_W-1:0]     arr_b1,
   output logic [DATA_W-1:0]     arr_b2,
   output logic [DATA_W-1:0]     arr_b3,
   output logic [DATA_W-1:0]     arr_b4,
   output logic                  arr_clear,
   input  logic [N*N*ACC_W-1:0]  c_in,
   output logic [N*N*ACC_W-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [31:0]           job_count
);

   localparam int CNT_MAX = (DRAIN_CYCLES > FEED_CYCLES) ? DRAIN_CYCLES : FEED_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   sa_state_t              state, state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [N*N*DATA_W-1:0]  a_lat, b_lat;
   logic [N*DATA_W-1:0]    a_op, b_op;
   logic                   accept, capture, feed_last, drain_last;

   assign feed_last  = (cnt == CNT_W'(FEED_CYCLES - 1));
   assign drain_last = (cnt == CNT_W'(DRAIN_CYCLES - 1));

   always_comb begin
      state_nxt    = state;
      start_ready  = (state == IDLE) && !abort;
      arr_clear    = (state == CLEAR);
      result_valid = (state == DONE);
      accept       = start_valid && start_ready;
      case (state)
         IDLE:    if (accept) state_nxt = CLEAR;
         CLEAR:   state_nxt = abort ? IDLE : FEED;
         FEED: begin
            if (abort)          state_nxt = IDLE;
            else if (feed_last) state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
         end
         DRAIN: begin
            if (abort)           state_nxt = IDLE;
            else if (drain_last) state_nxt = DONE;
         end
         DONE:    if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      capture = (state != DONE) && (state_nxt == DONE);
   end

   // The step counter only runs while staying in FEED or DRAIN; any transition rezeroes it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_lat  <= '0;
         b_lat  <= '0;
         result <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= ((state_nxt == state) && (state == FEED || state == DRAIN)) ? cnt + 1'b1 : '0;
         if (accept) begin
            a_lat <= a_mat;
            b_lat <= b_mat;
         end
         if (capture) result <= c_in;
      end
   end

   sa_skew_feeder u_feeder (
      .a_lat   (a_lat),
      .b_lat   (b_lat),
      .k       (cnt[K_W-1:0]),
      .feed_en (state == FEED),
      .a_op    (a_op),
      .b_op    (b_op)
   );

   assign {arr_a4, arr_a3, arr_a2, arr_a1} = a_op;
   assign {arr_b4, arr_b3, arr_b2, arr_b1} = b_op;

`ifdef SA_CTRL_PERF_EN
   logic [31:0] job_cnt_q;

   // Saturating count of result handshakes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         job_cnt_q <= '0;
      else if (result_valid && result_ready && (job_cnt_q != 32'hFFFF_FFFF))
         job_cnt_q <= job_cnt_q + 32'd1;
   end

   assign job_count = job_cnt_q;
`else
   assign job_count = 32'd0;
`endif

endmodule
